// File: rtl/mic1_sequencer_if.sv
// ---------------------------------------------------------------------------
// mic1_sequencer_if
// Purpose : bundles the MIC-1 sequencer's microinstruction, memory, ALU and
//           control-store address signals.
// Signals : start, mir_next_addr[8:0], mir_jmpc/jamn/jamz, mir_rd/wr/fetch,
//           mem_ready, alu_n, alu_z, mbr[7:0]           (towards sequencer)
//           mpc[8:0], mir_load, n_flag, z_flag, state[1:0], halted
//                                                        (from sequencer)
// Modports: master - the surrounding datapath / control store
//           slave  - the sequencer itself
// ---------------------------------------------------------------------------
interface mic1_sequencer_if;

   logic       start;
   logic [8:0] mir_next_addr;
   logic       mir_jmpc;
   logic       mir_jamn;
   logic       mir_jamz;
   logic       mir_rd;
   logic       mir_wr;
   logic       mir_fetch;
   logic       mem_ready;
   logic       alu_n;
   logic       alu_z;
   logic [7:0] mbr;

   logic [8:0] mpc;
   logic       mir_load;
   logic       n_flag;
   logic       z_flag;
   logic [1:0] state;
   logic       halted;

   modport master (
      output start, mir_next_addr, mir_jmpc, mir_jamn, mir_jamz,
             mir_rd, mir_wr, mir_fetch, mem_ready, alu_n, alu_z, mbr,
      input  mpc, mir_load, n_flag, z_flag, state, halted
   );

   modport slave (
      input  start, mir_next_addr, mir_jmpc, mir_jamn, mir_jamz,
             mir_rd, mir_wr, mir_fetch, mem_ready, alu_n, alu_z, mbr,
      output mpc, mir_load, n_flag, z_flag, state, halted
   );

endinterface

// File: rtl/mic1_sequencer.sv
// ---------------------------------------------------------------------------
// mic1_sequencer
// Purpose : MIC-1 microprogram sequencer. Computes the next control-store
//           address from NEXT_ADDRESS and the JAM bits, stalls on
//           outstanding memory requests and keeps the N/Z flags of the last
//           advancing microinstruction.
// Ports   : clk   - clock, rising edge
//           rst_n - asynchronous active-low reset
//           bus   - mic1_sequencer_if.slave (see interface file)
//             mir_load is combinational; every other output is registered.
// Config  : `define MIC1_HALT_DETECT_EN to enable HALT on a jam-free,
//           memory-free self-loop microinstruction. Without it HALT is
//           unreachable and halted is tied low.
// ---------------------------------------------------------------------------
module mic1_sequencer (
   input  logic                  clk,
   input  logic                  rst_n,
   mic1_sequencer_if.slave       bus
);

   localparam int unsigned ADDR_W = 9;
   localparam int unsigned BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_STALL = 2'b10,
      ST_HALT  = 2'b11
   } state_e;

   state_e              state_q;
   state_e              state_d;
   logic [ADDR_W-1:0]   mpc_q;
   logic [ADDR_W-1:0]   next_mpc;
   logic                n_q;
   logic                z_q;
   logic                mem_req;
   logic                advance;
   logic                halt_hit;

   // Next address and advance decode; the MBR merge is an OR, never an add.
   always_comb begin : seq_decode
      mem_req  = bus.mir_rd | bus.mir_wr | bus.mir_fetch;
      advance  = 1'b0;
      next_mpc = '0;
      next_mpc[ADDR_W-1] = bus.mir_next_addr[ADDR_W-1]
                         | (bus.mir_jamz & bus.alu_z)
                         | (bus.mir_jamn & bus.alu_n);
      next_mpc[BYTE_W-1:0] = bus.mir_jmpc
                           ? (bus.mir_next_addr[BYTE_W-1:0] | bus.mbr)
                           : bus.mir_next_addr[BYTE_W-1:0];
      case (state_q)
         ST_RUN:   advance = ~mem_req | bus.mem_ready;
         ST_STALL: advance = bus.mem_ready;
         default:  advance = 1'b0;
      endcase
   end

`ifdef MIC1_HALT_DETECT_EN
   // A microinstruction that jumps to itself with nothing else to do is a halt.
   assign halt_hit = (next_mpc == mpc_q)
                   & ~(bus.mir_jmpc | bus.mir_jamn | bus.mir_jamz)
                   & ~mem_req;
`else
   assign halt_hit = 1'b0;
`endif

   // Next-state logic; HALT is left only through reset.
   always_comb begin : seq_next_state
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (mem_req && !bus.mem_ready) state_d = ST_STALL;
            else if (halt_hit)             state_d = ST_HALT;
         end
         ST_STALL: begin
            if (bus.mem_ready) state_d = ST_RUN;
         end
         default: state_d = state_q;
      endcase
   end

   // State, MPC and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin : seq_regs
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mpc_q   <= '0;
         n_q     <= 1'b0;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (advance) begin
            mpc_q <= next_mpc;
            n_q   <= bus.alu_n;
            z_q   <= bus.alu_z;
         end
      end
   end

   // rst_n gates the IDLE+start term so MIR never loads while in reset.
   assign bus.mir_load = rst_n & (advance | ((state_q == ST_IDLE) & bus.start));
   assign bus.mpc      = mpc_q;
   assign bus.n_flag   = n_q;
   assign bus.z_flag   = z_q;
   assign bus.state    = state_q;

`ifdef MIC1_HALT_DETECT_EN
   assign bus.halted   = (state_q == ST_HALT);
`else
   assign bus.halted   = 1'b0;
`endif

endmodule

// File: tb/tb_mic1_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mic1_sequencer
// Purpose : self-checking bench for mic1_sequencer: directed scenarios with
//           fixed expected values, then randomized stimulus against a
//           behavioural sequencer model.
// ---------------------------------------------------------------------------
module tb_mic1_sequencer;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_STALL = 2;
   localparam int M_HALT  = 3;

`ifdef MIC1_HALT_DETECT_EN
   localparam bit HALT_EN = 1'b1;
`else
   localparam bit HALT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   // Behavioural model state.
   int m_state;
   int m_mpc;
   int m_n;
   int m_z;

   always #5 clk = ~clk;

   mic1_sequencer_if bus ();

   mic1_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- reference model ----------------
   function automatic int ref_next();
      int hi;
      int lo;
      hi = (bus.mir_next_addr[8] || (bus.mir_jamz && bus.alu_z) ||
            (bus.mir_jamn && bus.alu_n)) ? 1 : 0;
      lo = int'(bus.mir_next_addr[7:0]);
      if (bus.mir_jmpc) lo = lo | int'(bus.mbr);
      return hi * 256 + lo;
   endfunction

   function automatic bit ref_mem_req();
      return bus.mir_rd || bus.mir_wr || bus.mir_fetch;
   endfunction

   function automatic bit ref_advance();
      return (m_state == M_RUN && (!ref_mem_req() || bus.mem_ready)) ||
             (m_state == M_STALL && bus.mem_ready);
   endfunction

   function automatic bit ref_mir_load();
      return rst_n && (ref_advance() || (m_state == M_IDLE && bus.start));
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_mpc   = 0;
      m_n     = 0;
      m_z     = 0;
   endtask

   // Update the model from the inputs in force, then take one clock edge.
   task automatic tick();
      int nxt_state;
      int nxt_mpc;
      bit adv;
      adv       = ref_advance();
      nxt_mpc   = ref_next();
      nxt_state = m_state;
      case (m_state)
         M_IDLE:  if (bus.start) nxt_state = M_RUN;
         M_RUN: begin
            if (ref_mem_req() && !bus.mem_ready) nxt_state = M_STALL;
            else if (HALT_EN && nxt_mpc == m_mpc && !ref_mem_req() &&
                     !bus.mir_jmpc && !bus.mir_jamn && !bus.mir_jamz)
               nxt_state = M_HALT;
         end
         M_STALL: if (bus.mem_ready) nxt_state = M_RUN;
         default: nxt_state = m_state;
      endcase
      if (adv) begin
         m_mpc = nxt_mpc;
         m_n   = int'(bus.alu_n);
         m_z   = int'(bus.alu_z);
      end
      m_state = nxt_state;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.start         = 1'b0;
      bus.mir_next_addr = '0;
      bus.mir_jmpc      = 1'b0;
      bus.mir_jamn      = 1'b0;
      bus.mir_jamz      = 1'b0;
      bus.mir_rd        = 1'b0;
      bus.mir_wr        = 1'b0;
      bus.mir_fetch     = 1'b0;
      bus.mem_ready     = 1'b0;
      bus.alu_n         = 1'b0;
      bus.alu_z         = 1'b0;
      bus.mbr           = '0;
   endtask

   // ---------------- directed scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      clear_inputs();
      bus.start = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (bus.state !== 2'b00 || bus.mpc !== 9'h000 || bus.n_flag !== 1'b0 ||
          bus.z_flag !== 1'b0 || bus.halted !== 1'b0) begin
         bad++;
         $display("FAIL reset_state got st=%b mpc=%h n=%b z=%b h=%b want st=00 mpc=000 n=0 z=0 h=0",
                  bus.state, bus.mpc, bus.n_flag, bus.z_flag, bus.halted);
      end
      total++;
      if (bus.mir_load !== 1'b0) begin
         bad++;
         $display("FAIL reset_mir_load got=%b want=0", bus.mir_load);
      end
   endtask

   task automatic test_start();
      rst_n = 1'b1;
      #1;
      total++;
      if (bus.mir_load !== 1'b1 || bus.state !== 2'b00) begin
         bad++;
         $display("FAIL start_idle got ld=%b st=%b want ld=1 st=00", bus.mir_load, bus.state);
      end
      tick();
      bus.start = 1'b0;
      total++;
      if (bus.state !== 2'b01 || bus.mpc !== 9'h000) begin
         bad++;
         $display("FAIL start_run got st=%b mpc=%h want st=01 mpc=000", bus.state, bus.mpc);
      end
   endtask

   task automatic test_jamz();
      clear_inputs();
      bus.start         = 1'b1;   // must be ignored in RUN
      bus.mir_next_addr = 9'h0A5;
      bus.mir_jamz      = 1'b1;
      bus.alu_z         = 1'b1;
      #1;
      total++;
      if (bus.mir_load !== 1'b1) begin
         bad++;
         $display("FAIL jamz_mir_load got=%b want=1", bus.mir_load);
      end
      tick();
      total++;
      if (bus.mpc !== 9'h1A5 || bus.z_flag !== 1'b1 || bus.n_flag !== 1'b0 ||
          bus.state !== 2'b01) begin
         bad++;
         $display("FAIL jamz_advance got mpc=%h z=%b n=%b st=%b want mpc=1a5 z=1 n=0 st=01",
                  bus.mpc, bus.z_flag, bus.n_flag, bus.state);
      end
   endtask

   task automatic test_jmpc_wrap();
      clear_inputs();
      bus.mir_next_addr = 9'h1FF;
      tick();
      total++;
      if (bus.mpc !== 9'h1FF) begin
         bad++;
         $display("FAIL wrap_top got=%h want=1ff", bus.mpc);
      end
      bus.mir_next_addr = 9'h000;
      tick();
      total++;
      if (bus.mpc !== 9'h000) begin
         bad++;
         $display("FAIL wrap_zero got=%h want=000", bus.mpc);
      end
      bus.mir_jmpc      = 1'b1;
      bus.mir_next_addr = 9'h100;
      bus.mbr           = 8'h36;
      tick();
      total++;
      if (bus.mpc !== 9'h136) begin
         bad++;
         $display("FAIL jmpc_dispatch got=%h want=136", bus.mpc);
      end
      // Overlapping bits: OR gives 0x0FF where an add would give 0x10F.
      bus.mir_next_addr = 9'h0F0;
      bus.mbr           = 8'h1F;
      tick();
      total++;
      if (bus.mpc !== 9'h0FF) begin
         bad++;
         $display("FAIL jmpc_or got=%h want=0ff", bus.mpc);
      end
   endtask

   task automatic test_stall();
      clear_inputs();
      bus.mir_next_addr = 9'h077;
      bus.mir_rd        = 1'b1;
      bus.alu_n         = 1'b1;
      bus.alu_z         = 1'b1;
      #1;
      total++;
      if (bus.mir_load !== 1'b0) begin
         bad++;
         $display("FAIL stall_entry_load got=%b want=0", bus.mir_load);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         total++;
         if (bus.state !== 2'b10 || bus.mpc !== 9'h0FF || bus.n_flag !== 1'b0 ||
             bus.z_flag !== 1'b0 || bus.mir_load !== 1'b0) begin
            bad++;
            $display("FAIL stall_hold[%0d] got st=%b mpc=%h n=%b z=%b ld=%b want st=10 mpc=0ff n=0 z=0 ld=0",
                     i, bus.state, bus.mpc, bus.n_flag, bus.z_flag, bus.mir_load);
         end
      end
      bus.mem_ready = 1'b1;
      #1;
      total++;
      if (bus.mir_load !== 1'b1) begin
         bad++;
         $display("FAIL stall_release_load got=%b want=1", bus.mir_load);
      end
      tick();
      total++;
      if (bus.state !== 2'b01 || bus.mpc !== 9'h077 || bus.n_flag !== 1'b1 ||
          bus.z_flag !== 1'b1) begin
         bad++;
         $display("FAIL stall_release got st=%b mpc=%h n=%b z=%b want st=01 mpc=077 n=1 z=1",
                  bus.state, bus.mpc, bus.n_flag, bus.z_flag);
      end
   endtask

   task automatic test_reset_mid_stall();
      clear_inputs();
      bus.mir_next_addr = 9'h055;
      bus.mir_fetch     = 1'b1;
      tick();
      total++;
      if (bus.state !== 2'b10) begin
         bad++;
         $display("FAIL mid_stall_entry got st=%b want=10", bus.state);
      end
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      total++;
      if (bus.state !== 2'b00 || bus.mpc !== 9'h000 || bus.n_flag !== 1'b0 ||
          bus.z_flag !== 1'b0 || bus.mir_load !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got st=%b mpc=%h n=%b z=%b ld=%b want st=00 mpc=000 n=0 z=0 ld=0",
                  bus.state, bus.mpc, bus.n_flag, bus.z_flag, bus.mir_load);
      end
      #1;
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;   // late completion of the abandoned request
      tick();
      total++;
      if (bus.state !== 2'b00 || bus.mpc !== 9'h000) begin
         bad++;
         $display("FAIL abandoned_req got st=%b mpc=%h want st=00 mpc=000", bus.state, bus.mpc);
      end
      clear_inputs();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      total++;
      if (bus.state !== 2'b01 || bus.mpc !== 9'h000) begin
         bad++;
         $display("FAIL restart got st=%b mpc=%h want st=01 mpc=000", bus.state, bus.mpc);
      end
   endtask

   task automatic test_halt();
      clear_inputs();
      bus.mir_next_addr = 9'h042;
      tick();
      total++;
      if (bus.mpc !== 9'h042 || bus.state !== 2'b01) begin
         bad++;
         $display("FAIL halt_setup got mpc=%h st=%b want mpc=042 st=01", bus.mpc, bus.state);
      end
      #1;
      total++;
      if (bus.mir_load !== 1'b1) begin
         bad++;
         $display("FAIL self_loop_load got=%b want=1", bus.mir_load);
      end
      tick();
`ifdef MIC1_HALT_DETECT_EN
      total++;
      if (bus.state !== 2'b11 || bus.halted !== 1'b1 || bus.mpc !== 9'h042) begin
         bad++;
         $display("FAIL halt_entry got st=%b h=%b mpc=%h want st=11 h=1 mpc=042",
                  bus.state, bus.halted, bus.mpc);
      end
      for (int i = 0; i < 3; i++) begin
         bus.start         = 1'b1;
         bus.mir_next_addr = 9'h011;
         bus.mem_ready     = 1'b1;
         #1;
         total++;
         if (bus.mir_load !== 1'b0) begin
            bad++;
            $display("FAIL halt_load[%0d] got=%b want=0", i, bus.mir_load);
         end
         tick();
         total++;
         if (bus.state !== 2'b11 || bus.mpc !== 9'h042 || bus.halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_hold[%0d] got st=%b mpc=%h h=%b want st=11 mpc=042 h=1",
                     i, bus.state, bus.mpc, bus.halted);
         end
      end
`else
      total++;
      if (bus.state !== 2'b01 || bus.halted !== 1'b0 || bus.mpc !== 9'h042) begin
         bad++;
         $display("FAIL self_loop got st=%b h=%b mpc=%h want st=01 h=0 mpc=042",
                  bus.state, bus.halted, bus.mpc);
      end
      #1;
      total++;
      if (bus.mir_load !== 1'b1) begin
         bad++;
         $display("FAIL self_loop_reload got=%b want=1", bus.mir_load);
      end
`endif
   endtask

   // ---------------- randomized run against the model ----------------
   task automatic test_random();
      rst_n = 1'b0;
      clear_inputs();
      model_reset();
      #1;
      rst_n = 1'b1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         // The MIR holds its fields steady while a request is stalled.
         if (m_state != M_STALL) begin
            bus.mir_next_addr = 9'($urandom_range(0, 511));
            bus.mir_jmpc      = ($urandom_range(0, 3) == 0);
            bus.mir_jamn      = ($urandom_range(0, 3) == 0);
            bus.mir_jamz      = ($urandom_range(0, 3) == 0);
            bus.mir_rd        = ($urandom_range(0, 5) == 0);
            bus.mir_wr        = ($urandom_range(0, 7) == 0);
            bus.mir_fetch     = ($urandom_range(0, 5) == 0);
            bus.alu_n         = 1'($urandom_range(0, 1));
            bus.alu_z         = 1'($urandom_range(0, 1));
            bus.mbr           = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) begin
               bus.mir_next_addr = 9'(m_mpc);
               bus.mir_jmpc      = 1'b0;
               bus.mir_jamn      = 1'b0;
               bus.mir_jamz      = 1'b0;
            end
         end
         bus.mem_ready = 1'($urandom_range(0, 1));
         bus.start     = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 47) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            total++;
            if (int'(bus.state) !== m_state || int'(bus.mpc) !== m_mpc) begin
               bad++;
               $display("FAIL rnd_reset[%0d] got st=%0d mpc=%h want st=%0d mpc=%h",
                        cyc, bus.state, bus.mpc, m_state, m_mpc);
            end
            rst_n = 1'b1;
         end
         #1;
         total++;
         if (bus.mir_load !== ref_mir_load()) begin
            bad++;
            $display("FAIL rnd_mir_load[%0d] got=%b want=%b", cyc, bus.mir_load, ref_mir_load());
         end
         tick();
         total++;
         if (int'(bus.state) !== m_state || int'(bus.mpc) !== m_mpc ||
             int'(bus.n_flag) !== m_n || int'(bus.z_flag) !== m_z ||
             int'(bus.halted) !== ((m_state == M_HALT) ? 1 : 0)) begin
            bad++;
            $display("FAIL rnd_regs[%0d] got st=%0d mpc=%h n=%b z=%b h=%b want st=%0d mpc=%h n=%0d z=%0d",
                     cyc, bus.state, bus.mpc, bus.n_flag, bus.z_flag, bus.halted,
                     m_state, m_mpc, m_n, m_z);
         end
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_jamz();
      test_jmpc_wrap();
      test_stall();
      test_reset_mid_stall();
      test_halt();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mic1_sequencer.md
MIC1_SEQUENCER -- requirements
Module: mic1_sequencer

Interface
REQ-001 SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have the port start, input, 1 bit: begin microprogram execution; honoured in IDLE only.
REQ-004 SHALL have the port mir_next_addr, input, 9 bits: NEXT_ADDRESS field of the current microinstruction.
REQ-005 SHALL have the ports mir_jmpc, mir_jamn and mir_jamz, inputs, 1 bit each: the JAM field bits.
REQ-006 SHALL have the ports mir_rd, mir_wr and mir_fetch, inputs, 1 bit each: memory requests of the current microinstruction.
REQ-007 SHALL have the port mem_ready, input, 1 bit: memory has completed the outstanding request.
REQ-008 SHALL have the ports alu_n and alu_z, inputs, 1 bit each: N and Z outputs of the ALU for the current microinstruction.
REQ-009 SHALL have the port mbr, input, 8 bits: the MBR byte used for JMPC dispatch.
REQ-010 SHALL have the port mpc, output, 9 bits: registered control-store address.
REQ-011 SHALL have the port mir_load, output, 1 bit: combinational; MIR captures control_store[next mpc] at the next edge.
REQ-012 SHALL have the ports n_flag and z_flag, outputs, 1 bit each: registered N and Z captured at the last advance.
REQ-013 SHALL have the port state, output, 2 bits: IDLE=00, RUN=01, STALL=10, HALT=11.
REQ-014 SHALL have the port halted, output, 1 bit: high while state is HALT.

Function
REQ-015 SHALL define mem_req = mir_rd | mir_wr | mir_fetch.
REQ-016 SHALL define advance = (RUN and (!mem_req or mem_ready)) or (STALL and mem_ready).
REQ-017 SHALL compute next_mpc[8] = mir_next_addr[8] | (mir_jamz & alu_z) | (mir_jamn & alu_n).
REQ-018 SHALL compute next_mpc[7:0] = mir_jmpc ? (mir_next_addr[7:0] | mbr) : mir_next_addr[7:0]; this is a bitwise OR, never an add or a carry.
REQ-019 SHALL, on each edge where advance is high, load mpc with next_mpc and load n_flag/z_flag with alu_n/alu_z.
REQ-020 SHALL hold mpc, n_flag and z_flag unchanged on every edge where advance is low.
REQ-021 SHALL assert mir_load when advance is high, or when state is IDLE and start is high; it is low otherwise.
REQ-022 SHALL transition IDLE to RUN on start; mpc stays 0, so the first microinstruction is taken from address 0.
REQ-023 SHALL transition RUN to STALL when mem_req=1 and mem_ready=0; the edge does not advance.
REQ-024 SHALL stay in STALL while mem_ready=0, and return STALL to RUN on the edge where mem_ready=1, advancing on that edge.
REQ-025 SHALL keep all sequencing inputs stable while in STALL, as guaranteed by the MIR holding them; the ALU flags used are those sampled at the advancing edge.
REQ-026 SHALL ignore start outside IDLE.
REQ-027 SHALL have no path from RUN, STALL or HALT back to IDLE except reset.
REQ-028 SHALL let a wrap from next_mpc 0x1FF to 0x000 occur naturally through NEXT_ADDRESS, with no special handling.

Reset
REQ-029 SHALL, on rst_n low, immediately force state=IDLE, mpc=0, n_flag=0, z_flag=0 and halted=0, independent of clk.
REQ-030 SHALL, when reset is asserted mid-STALL, abandon the pending memory request; the sequencer does not remember it after release.
REQ-031 SHALL keep mir_load low while rst_n is low.

Configuration
REQ-032 SHALL, with macro MIC1_HALT_DETECT_EN defined, enter HALT on an advancing RUN edge when next_mpc==mpc, all three JAM bits are 0 and mem_req=0.
REQ-033 SHALL, with MIC1_HALT_DETECT_EN defined, leave HALT only by reset, with mir_load=0 and mpc frozen while in HALT.
REQ-034 SHALL, without MIC1_HALT_DETECT_EN, make HALT unreachable: halted tied to 0, and a self-loop microinstruction re-executes every cycle.

Verification
REQ-035 SHALL cover: reset, then start pulse -> state 00 to 01, mir_load=1 that cycle, mpc=0x000.
REQ-036 SHALL cover: RUN with next_addr=0x0A5, jamz=1, alu_z=1 -> mpc=0x1A5 next edge, z_flag=1.
REQ-037 SHALL cover: jmpc=1, next_addr=0x100, mbr=0x36 -> mpc=0x136.
REQ-038 SHALL cover: mir_rd=1, mem_ready low for 3 cycles -> state=10 for 3 cycles, mpc and flags held, mir_load=0; mem_ready=1 -> advance, state=01.
REQ-039 SHALL cover: rst_n asserted mid-STALL between edges -> outputs reset asynchronously, state=00, mpc=0.
REQ-040 SHALL cover: with MIC1_HALT_DETECT_EN, mpc=0x042 and next_addr=0x042 with no JAM -> halted=1, state=11, stays until reset; without the macro, mpc remains 0x042 and state=01.
